// File: rtl/signed_minmax_tracker_pkg.sv
// Shared definitions for the signed min/max tracker: state encoding and
// default field widths.
package signed_minmax_tracker_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = 8;

  // IDLE waits for the first beat of a frame, ACC accumulates the rest,
  // HOLD presents the frame result until the sink takes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/signed_minmax_tracker_minmax_update.sv
// Combinational min/max step: folds one new signed sample into the running
// extremes. Strict compares keep the earliest index on ties.
module minmax_update
  import signed_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic signed [WIDTH-1:0] cur_min,
  input  logic signed [WIDTH-1:0] cur_max,
  input  logic        [IDX_W-1:0] cur_min_idx,
  input  logic        [IDX_W-1:0] cur_max_idx,
  input  logic        [IDX_W-1:0] idx,
  input  logic signed [WIDTH-1:0] sample,
  output logic signed [WIDTH-1:0] nxt_min,
  output logic signed [WIDTH-1:0] nxt_max,
  output logic        [IDX_W-1:0] nxt_min_idx,
  output logic        [IDX_W-1:0] nxt_max_idx
);

  // Replace an extreme only when the sample is strictly beyond it.
  always_comb begin
    nxt_min     = cur_min;
    nxt_max     = cur_max;
    nxt_min_idx = cur_min_idx;
    nxt_max_idx = cur_max_idx;
    if (sample < cur_min) begin
      nxt_min     = sample;
      nxt_min_idx = idx;
    end
    if (sample > cur_max) begin
      nxt_max     = sample;
      nxt_max_idx = idx;
    end
  end

endmodule

// File: rtl/signed_minmax_tracker.sv
// Framed signed min/max tracker. Accepts samples over valid/ready, tracks the
// running signed extremes with first-occurrence indices, and presents one
// result beat per frame. All m_* outputs come straight from registers.
module signed_minmax_tracker
  import signed_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_min,
  output logic signed [WIDTH-1:0] m_max,
  output logic        [IDX_W-1:0] m_min_idx,
  output logic        [IDX_W-1:0] m_max_idx,
  output logic        [IDX_W-1:0] m_count,
  output logic                    m_sat
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  // Count/index step that parks at the all-ones value.
  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_MAX) ? v : v + IDX_W'(1);
  endfunction

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] min_q, max_q;
  logic        [IDX_W-1:0] min_idx_q, max_idx_q, cnt_q;
  logic                    sat_q;

  logic signed [WIDTH-1:0] upd_min, upd_max;
  logic        [IDX_W-1:0] upd_min_idx, upd_max_idx;

  logic xfer;
  logic hs;

  assign xfer = s_valid && s_ready;
  assign hs   = m_valid && m_ready;

  // The sample index is the running count, saturated with it.
  minmax_update #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_update (
    .cur_min     (min_q),
    .cur_max     (max_q),
    .cur_min_idx (min_idx_q),
    .cur_max_idx (max_idx_q),
    .idx         (cnt_q),
    .sample      (s_data),
    .nxt_min     (upd_min),
    .nxt_max     (upd_max),
    .nxt_min_idx (upd_min_idx),
    .nxt_max_idx (upd_max_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; HOLD blocks new samples entirely.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b1;
    m_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) state_nxt = s_last ? ST_HOLD : ST_ACC;
      end
      ST_ACC: begin
        if (xfer && s_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        if (hs) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Running extremes, indices, count and overflow flag; first beat reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else if (xfer) begin
      if (state == ST_IDLE) begin
        min_q     <= s_data;
        max_q     <= s_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
        cnt_q     <= IDX_W'(1);
        sat_q     <= 1'b0;
      end else begin
        min_q     <= upd_min;
        max_q     <= upd_max;
        min_idx_q <= upd_min_idx;
        max_idx_q <= upd_max_idx;
        cnt_q     <= sat_inc(cnt_q);
        if (cnt_q == IDX_MAX) sat_q <= 1'b1;
      end
    end
  end

  assign m_min     = min_q;
  assign m_max     = max_q;
  assign m_min_idx = min_idx_q;
  assign m_max_idx = max_idx_q;
  assign m_count   = cnt_q;
  assign m_sat     = sat_q;

endmodule
